// File: rtl/bird_physics.sv
// Per-frame vertical motion engine for the flappy bird: row, velocity and IDLE/PLAY/DEAD state.
// Optional IDLE hover bob is enabled by defining BIRD_HOVER_EN.
module bird_physics #(
    parameter int Y_START  = 240,
    parameter int Y_MIN    = 6,
    parameter int Y_MAX    = 474,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -7,
    parameter int V_MAX    = 9
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        frame_tick,
    input  logic        flap,
    input  logic        collide,
    output logic [31:0] bird_y,
    output logic        playing,
    output logic        game_over
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DEAD
    } state_t;

    localparam logic signed [10:0] YS  = 11'(Y_START);
    localparam logic signed [10:0] YLO = 11'(Y_MIN);
    localparam logic signed [10:0] YHI = 11'(Y_MAX);
    localparam logic signed [7:0]  FV  = 8'(FLAP_VEL);
    localparam logic signed [8:0]  GV  = 9'(GRAVITY);
    localparam logic signed [8:0]  VM  = 9'(V_MAX);

    state_t state_q, state_d;
    logic signed [10:0] y_q, y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic flap_prev_q, flap_prev_d;
    logic flap_pend_q, flap_pend_d;
    logic playing_q, playing_d;
    logic game_over_q, game_over_d;

    logic               flap_rise;
    logic               flap_req;
    logic signed [8:0]  vel_inc;
    logic signed [7:0]  v_new;
    logic signed [10:0] y_next;

`ifdef BIRD_HOVER_EN
    logic [3:0] hov_q, hov_d;
`endif

    always_comb begin
        flap_rise = flap & ~flap_prev_q;
        flap_req  = flap_pend_q | flap_rise;

        // Wider add so a large velocity plus gravity cannot wrap before saturation.
        vel_inc = {vel_q[7], vel_q} + GV;
        if (flap_req) begin
            v_new = FV;
        end else if (vel_inc > VM) begin
            v_new = VM[7:0];
        end else begin
            v_new = vel_inc[7:0];
        end
        y_next = y_q + 11'(v_new);

        flap_prev_d = flap;
        flap_pend_d = frame_tick ? 1'b0 : flap_req;
        state_d     = state_q;
        y_d         = y_q;
        vel_d       = vel_q;
`ifdef BIRD_HOVER_EN
        hov_d       = hov_q;
`endif

        if (frame_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (flap_req) begin
                        state_d = PLAY;
                        y_d     = y_next;
                        vel_d   = FV;
`ifdef BIRD_HOVER_EN
                        hov_d   = 4'd0;
`endif
                    end else begin
                        vel_d = 8'sd0;
`ifdef BIRD_HOVER_EN
                        hov_d = hov_q + 4'd1;
                        y_d   = hov_d[3] ? (YS - 11'sd2) : YS;
`else
                        y_d   = YS;
`endif
                    end
                end
                PLAY: begin
                    // Collision freezes the bird where it is, even over a flap.
                    if (collide) begin
                        state_d = DEAD;
                    end else if (y_next >= YHI) begin
                        y_d     = YHI;
                        vel_d   = 8'sd0;
                        state_d = DEAD;
                    end else if (y_next < YLO) begin
                        y_d   = YLO;
                        vel_d = 8'sd0;
                    end else begin
                        y_d   = y_next;
                        vel_d = v_new;
                    end
                end
                DEAD: begin
                    if (flap_req) begin
                        state_d = IDLE;
                        y_d     = YS;
                        vel_d   = 8'sd0;
`ifdef BIRD_HOVER_EN
                        hov_d   = 4'd0;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    y_d     = YS;
                    vel_d   = 8'sd0;
                end
            endcase
        end

        playing_d   = (state_d == PLAY);
        game_over_d = (state_d == DEAD);
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            y_q         <= YS;
            vel_q       <= 8'sd0;
            flap_prev_q <= 1'b0;
            flap_pend_q <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
`ifdef BIRD_HOVER_EN
            hov_q       <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            flap_prev_q <= flap_prev_d;
            flap_pend_q <= flap_pend_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
`ifdef BIRD_HOVER_EN
            hov_q       <= hov_d;
`endif
        end
    end

    assign bird_y    = {21'b0, y_q};
    assign playing   = playing_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: idle, flap arc, free fall, ceiling clamp, collision, restart.
module tb_bird_physics;

    logic        clock;
    logic        reset_L;
    logic        frame_tick;
    logic        flap;
    logic        collide;
    logic [31:0] bird_y;
    logic        playing;
    logic        game_over;

    int total = 0;
    int bad   = 0;

    bird_physics dut (
        .clock      (clock),
        .reset_L    (reset_L),
        .frame_tick (frame_tick),
        .flap       (flap),
        .collide    (collide),
        .bird_y     (bird_y),
        .playing    (playing),
        .game_over  (game_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic pulse_flap();
        @(negedge clock);
        flap = 1'b1;
        @(negedge clock);
        flap = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_L = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_L = 1'b1;
    endtask

    int  ev;
    int  ey;
    logic dead;

    initial begin
        reset_L    = 1'b0;
        frame_tick = 1'b0;
        flap       = 1'b0;
        collide    = 1'b0;
        do_reset();

        check("rst_y", bird_y, 240);
        check("rst_play", {31'b0, playing}, 0);
        check("rst_go", {31'b0, game_over}, 0);

`ifdef BIRD_HOVER_EN
        for (int n = 1; n <= 32; n++) begin
            tick();
            check("hover_y", bird_y, ((n % 16) >= 8) ? 238 : 240);
        end
        do_reset();
`else
        for (int n = 0; n < 5; n++) begin
            tick();
            check("idle_y", bird_y, 240);
            check("idle_play", {31'b0, playing}, 0);
        end
`endif

        // Flap between ticks must not move the bird until the tick.
        pulse_flap();
        check("pend_hold", bird_y, 240);
        tick();
        check("start_play", {31'b0, playing}, 1);
        check("start_y", bird_y, 233);
        tick();
        check("arc1", bird_y, 227);
        tick();
        check("arc2", bird_y, 222);
        tick();
        check("arc3", bird_y, 218);

        ev   = -4;
        ey   = 218;
        dead = 1'b0;
        for (int i = 0; i < 40 && !dead; i++) begin
            tick();
            ev = (ev + 1 > 9) ? 9 : ev + 1;
            ey = ey + ev;
            if (ey >= 474) begin
                ey   = 474;
                dead = 1'b1;
            end
            check("fall_y", bird_y, ey);
            check("fall_go", {31'b0, game_over}, {31'b0, dead});
        end
        check("fall_dead", {31'b0, game_over}, 1);
        check("fall_play", {31'b0, playing}, 0);
        tick();
        check("ground_hold1", bird_y, 474);
        tick();
        check("ground_hold2", bird_y, 474);

        pulse_flap();
        tick();
        check("restart_y", bird_y, 240);
        check("restart_play", {31'b0, playing}, 0);
        check("restart_go", {31'b0, game_over}, 0);

        // Flap rise in the tick cycle itself; held level must not re-flap.
        @(negedge clock);
        flap       = 1'b1;
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        check("same_cyc_y", bird_y, 233);
        check("same_cyc_play", {31'b0, playing}, 1);
        tick();
        check("held_flap_y", bird_y, 227);
        @(negedge clock);
        flap = 1'b0;

        ey = 227;
        ev = -6;
        for (int i = 0; i < 36; i++) begin
            pulse_flap();
            tick();
            ey = ey - 7;
            if (ey < 6) ey = 6;
            check("top_y", bird_y, ey);
            check("top_play", {31'b0, playing}, 1);
        end
        tick();
        check("after_clamp_y", bird_y, 7);

        @(negedge clock);
        collide    = 1'b1;
        flap       = 1'b1;
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        collide    = 1'b0;
        flap       = 1'b0;
        check("coll_y", bird_y, 7);
        check("coll_go", {31'b0, game_over}, 1);
        check("coll_play", {31'b0, playing}, 0);
        tick();
        check("dead_hold_y", bird_y, 7);
        check("dead_hold_go", {31'b0, game_over}, 1);
        pulse_flap();
        tick();
        check("revive_y", bird_y, 240);
        check("revive_go", {31'b0, game_over}, 0);

        pulse_flap();
        tick();
        check("replay", {31'b0, playing}, 1);
        @(negedge clock);
        reset_L    = 1'b0;
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        reset_L    = 1'b1;
        check("mid_rst_y", bird_y, 240);
        check("mid_rst_play", {31'b0, playing}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
